// File: rtl/eth_tx_arb.sv
// Packet-granular arbiter sharing one eth_tx application interface between REQ_N sources.
// Round-robin by default; define ETH_TX_ARB_PRIO_EN for strict lowest-index-first priority.
module eth_tx_arb #(
  parameter int REQ_N          = 2,
  parameter int DATA_W         = 16,
  parameter int KEEP_W         = DATA_W / 8,
  parameter int LEN_W          = $clog2(KEEP_W + 1),
  parameter int PKT_LEN_W      = 16,
  parameter int UDP_CS_W       = 16,
  parameter int BLOCK_N        = 8,
  parameter int APP_LAST_LEN_W = $clog2(BLOCK_N + KEEP_W + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [REQ_N-1:0]                  req_early_v_i,
  output logic [REQ_N-1:0]                  req_ready_v_o,
  input  logic [REQ_N-1:0]                  req_cancel_i,
  input  logic [REQ_N*DATA_W-1:0]           req_data_i,
  input  logic [REQ_N*LEN_W-1:0]            req_len_i,
  input  logic [REQ_N*PKT_LEN_W-1:0]        req_pkt_len_i,
  input  logic [REQ_N*UDP_CS_W-1:0]         req_cs_i,
  input  logic [REQ_N-1:0]                  req_last_i,
  input  logic [REQ_N-1:0]                  req_last_block_next_i,
  input  logic [REQ_N*APP_LAST_LEN_W-1:0]   req_last_block_next_len_i,
  output logic                              app_early_v_o,
  input  logic                              app_ready_v_i,
  output logic                              app_cancel_o,
  output logic [DATA_W-1:0]                 app_data_o,
  output logic [LEN_W-1:0]                  app_len_o,
  output logic [PKT_LEN_W-1:0]              app_pkt_len_o,
  output logic [UDP_CS_W-1:0]               app_cs_o,
  output logic                              app_last_o,
  output logic                              app_last_block_next_o,
  output logic [APP_LAST_LEN_W-1:0]         app_last_block_next_len_o,
  output logic [REQ_N-1:0]                  grant_o,
  output logic [15:0]                       pkt_cnt_o
);

  localparam int IDX_W = $clog2(REQ_N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               ptr_move;
  logic               route_ready;

  logic                      own_early;
  logic                      own_cancel;
  logic                      own_last;
  logic                      own_lbn;
  logic [DATA_W-1:0]         own_data;
  logic [LEN_W-1:0]          own_len;
  logic [PKT_LEN_W-1:0]      own_pkt_len;
  logic [UDP_CS_W-1:0]       own_cs;
  logic [APP_LAST_LEN_W-1:0] own_lbn_len;

  // Owner-side view of every requester field.
  always_comb begin
    own_early   = 1'b0;
    own_cancel  = 1'b0;
    own_last    = 1'b0;
    own_lbn     = 1'b0;
    own_data    = '0;
    own_len     = '0;
    own_pkt_len = '0;
    own_cs      = '0;
    own_lbn_len = '0;
    for (int r = 0; r < REQ_N; r++) begin
      if (owner_q == IDX_W'(r)) begin
        own_early   = req_early_v_i[r];
        own_cancel  = req_cancel_i[r];
        own_last    = req_last_i[r];
        own_lbn     = req_last_block_next_i[r];
        own_data    = req_data_i[r*DATA_W +: DATA_W];
        own_len     = req_len_i[r*LEN_W +: LEN_W];
        own_pkt_len = req_pkt_len_i[r*PKT_LEN_W +: PKT_LEN_W];
        own_cs      = req_cs_i[r*UDP_CS_W +: UDP_CS_W];
        own_lbn_len = req_last_block_next_len_i[r*APP_LAST_LEN_W +: APP_LAST_LEN_W];
      end
    end
  end

`ifdef ETH_TX_ARB_PRIO_EN
  // Walk from the top down so the lowest requesting index is the last write.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      if (req_early_v_i[IDX_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Search starts one past the last owner that finished (last or cancel).
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < REQ_N; k++) begin
      cand = (int'(rr_ptr_q) + 1 + k) % REQ_N;
      if (!win_found && req_early_v_i[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ptr_move) rr_ptr_d = owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= IDX_W'(REQ_N - 1);
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    state_d                   = state_q;
    owner_d                   = owner_q;
    pkt_cnt_d                 = pkt_cnt_q;
    ptr_move                  = 1'b0;
    route_ready               = 1'b0;
    app_early_v_o             = 1'b0;
    app_cancel_o              = 1'b0;
    app_data_o                = '0;
    app_len_o                 = '0;
    app_pkt_len_o             = '0;
    app_cs_o                  = '0;
    app_last_o                = 1'b0;
    app_last_block_next_o     = 1'b0;
    app_last_block_next_len_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_HEAD;
          owner_d = win_idx;
        end
      end
      ST_HEAD: begin
        app_early_v_o = own_early;
        app_pkt_len_o = own_pkt_len;
        app_cs_o      = own_cs;
        if (own_cancel) begin
          app_cancel_o = 1'b1;
          ptr_move     = 1'b1;
          state_d      = ST_IDLE;
        end else if (!own_early) begin
          // Withdrawn before the header was accepted: nothing was sent downstream.
          state_d = ST_IDLE;
        end else begin
          route_ready = 1'b1;
          if (app_ready_v_i) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        app_data_o                = own_data;
        app_len_o                 = own_len;
        app_last_block_next_o     = own_lbn;
        app_last_block_next_len_o = own_lbn_len;
        if (own_cancel) begin
          app_cancel_o = 1'b1;
          ptr_move     = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          route_ready = 1'b1;
          if (own_last) begin
            app_last_o = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            ptr_move   = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The app side must see a quiet interface for the whole reset cycle.
    if (reset) begin
      route_ready               = 1'b0;
      app_early_v_o             = 1'b0;
      app_cancel_o              = 1'b0;
      app_data_o                = '0;
      app_len_o                 = '0;
      app_pkt_len_o             = '0;
      app_cs_o                  = '0;
      app_last_o                = 1'b0;
      app_last_block_next_o     = 1'b0;
      app_last_block_next_len_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign grant_o       = (state_q != ST_IDLE && !reset) ? (REQ_N'(1) << owner_q) : '0;
  assign req_ready_v_o = (route_ready && app_ready_v_i) ? (REQ_N'(1) << owner_q) : '0;
  assign pkt_cnt_o     = pkt_cnt_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: single packet, contention, cancel, withdraw, reset mid-packet.
// Expected grant order switches to fixed priority when ETH_TX_ARB_PRIO_EN is defined.
module tb_eth_tx_arb;

  localparam int REQ_N          = 2;
  localparam int DATA_W         = 16;
  localparam int LEN_W          = 2;
  localparam int PKT_LEN_W      = 16;
  localparam int UDP_CS_W       = 16;
  localparam int APP_LAST_LEN_W = 4;

  logic                            clk;
  logic                            reset;
  logic [REQ_N-1:0]                req_early_v;
  logic [REQ_N-1:0]                req_ready_v;
  logic [REQ_N-1:0]                req_cancel;
  logic [REQ_N*DATA_W-1:0]         req_data;
  logic [REQ_N*LEN_W-1:0]          req_len;
  logic [REQ_N*PKT_LEN_W-1:0]      req_pkt_len;
  logic [REQ_N*UDP_CS_W-1:0]       req_cs;
  logic [REQ_N-1:0]                req_last;
  logic [REQ_N-1:0]                req_lbn;
  logic [REQ_N*APP_LAST_LEN_W-1:0] req_lbn_len;
  logic                            app_early_v;
  logic                            app_ready_v;
  logic                            app_cancel;
  logic [DATA_W-1:0]               app_data;
  logic [LEN_W-1:0]                app_len;
  logic [PKT_LEN_W-1:0]            app_pkt_len;
  logic [UDP_CS_W-1:0]             app_cs;
  logic                            app_last;
  logic                            app_lbn;
  logic [APP_LAST_LEN_W-1:0]       app_lbn_len;
  logic [REQ_N-1:0]                grant;
  logic [15:0]                     pkt_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  eth_tx_arb dut (
    .clk                       (clk),
    .reset                     (reset),
    .req_early_v_i             (req_early_v),
    .req_ready_v_o             (req_ready_v),
    .req_cancel_i              (req_cancel),
    .req_data_i                (req_data),
    .req_len_i                 (req_len),
    .req_pkt_len_i             (req_pkt_len),
    .req_cs_i                  (req_cs),
    .req_last_i                (req_last),
    .req_last_block_next_i     (req_lbn),
    .req_last_block_next_len_i (req_lbn_len),
    .app_early_v_o             (app_early_v),
    .app_ready_v_i             (app_ready_v),
    .app_cancel_o              (app_cancel),
    .app_data_o                (app_data),
    .app_len_o                 (app_len),
    .app_pkt_len_o             (app_pkt_len),
    .app_cs_o                  (app_cs),
    .app_last_o                (app_last),
    .app_last_block_next_o     (app_lbn),
    .app_last_block_next_len_o (app_lbn_len),
    .grant_o                   (grant),
    .pkt_cnt_o                 (pkt_cnt)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic obs();
    #1;
  endtask

  task automatic clear_inputs();
    req_early_v = '0;
    req_cancel  = '0;
    req_data    = '0;
    req_len     = '0;
    req_pkt_len = '0;
    req_cs      = '0;
    req_last    = '0;
    req_lbn     = '0;
    req_lbn_len = '0;
    app_ready_v = 1'b0;
  endtask

  task automatic set_word(input int r, input logic [15:0] d, input logic last,
                          input logic lbn, input logic [3:0] lbn_len);
    req_data[r*DATA_W +: DATA_W]                 = d;
    req_len[r*LEN_W +: LEN_W]                    = 2'd2;
    req_last[r]                                  = last;
    req_lbn[r]                                   = lbn;
    req_lbn_len[r*APP_LAST_LEN_W +: APP_LAST_LEN_W] = lbn_len;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    cyc();
    obs();
    check("rst_grant", grant, 0);
    check("rst_early", app_early_v, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int own_seq[3];
    logic [1:0] g;
`ifdef ETH_TX_ARB_PRIO_EN
    own_seq = '{0, 0, 0};
`else
    own_seq = '{0, 1, 0};
`endif
    reset = 1'b1;
    clear_inputs();

    // 1. Single requester, 20-byte packet, ready after 3 header cycles.
    do_reset();
    req_early_v[0] = 1'b1;
    req_pkt_len[15:0] = 16'd20;
    req_cs[15:0] = 16'hBEEF;
    obs();
    check("t1_idle_grant", grant, 0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 3) app_ready_v = 1'b1;
      obs();
      check("t1_head_early", app_early_v, 1);
      check("t1_head_grant", grant, 2'b01);
      check("t1_head_ready", req_ready_v, (c == 3) ? 2'b01 : 2'b00);
    end
    check("t1_pkt_len", app_pkt_len, 20);
    check("t1_cs", app_cs, 16'hBEEF);
    for (int w = 1; w <= 10; w++) begin
      cyc();
      app_ready_v = 1'b0;
      req_early_v[0] = 1'b0;
      set_word(0, 16'hA000 + 16'(w), w == 10, w == 8, (w == 8) ? 4'd4 : 4'd0);
      obs();
      check("t1_data", app_data, 16'hA000 + w);
      check("t1_last", app_last, (w == 10) ? 1 : 0);
      check("t1_grant", grant, 2'b01);
      check("t1_early_off", app_early_v, 0);
      if (w == 8) begin
        check("t1_lbn", app_lbn, 1);
        check("t1_lbn_len", app_lbn_len, 4);
        check("t1_len", app_len, 2);
      end
    end
    cyc();
    clear_inputs();
    obs();
    check("t1_end_grant", grant, 0);
    check("t1_end_pkt_cnt", pkt_cnt, 1);
    check("t1_end_data", app_data, 0);

    // 2. Contention: both hold early_v; three 2-word packets.
    do_reset();
    req_early_v = 2'b11;
    req_pkt_len = {16'd4, 16'd4};
    obs();
    check("t2_idle_grant", grant, 0);
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(2'b01 << own_seq[p]);
      exp_q.push_back(2'b00);
    end
    for (int p = 0; p < 3; p++) begin
      cyc();
      app_ready_v = 1'b1;
      obs();
      g = exp_q.pop_front();
      check("t2_grant", grant, g);
      check("t2_ready_route", req_ready_v, g);
      for (int w = 1; w <= 2; w++) begin
        cyc();
        app_ready_v = 1'b0;
        for (int r = 0; r < REQ_N; r++)
          set_word(r, 16'h1000 * 16'(r + 1) + 16'(p * 16 + w),
                   (w == 2) || (r != own_seq[p]), 1'b0, 4'd0);
        if (w == 2 && p == 2) req_early_v = 2'b00;
        obs();
        check("t2_data", app_data, 16'h1000 * (own_seq[p] + 1) + p * 16 + w);
        check("t2_last", app_last, (w == 2) ? 1 : 0);
      end
      cyc();
      req_last = '0;
      req_data = '0;
      obs();
      g = exp_q.pop_front();
      check("t2_idle", grant, g);
      check("t2_pkt_cnt", pkt_cnt, p + 1);
    end

    // 3. Cancel by req1 on its 2nd word; req0 cancel ignored.
    req_early_v[1] = 1'b1;
    cyc();
    app_ready_v = 1'b1;
    obs();
    check("t3_head_grant", grant, 2'b10);
    cyc();
    app_ready_v = 1'b0;
    req_early_v = 2'b00;
    req_cancel[0] = 1'b1;
    set_word(1, 16'hC001, 1'b0, 1'b0, 4'd0);
    obs();
    check("t3_foreign_cancel", app_cancel, 0);
    check("t3_grant_hold", grant, 2'b10);
    check("t3_data", app_data, 16'hC001);
    cyc();
    req_cancel = 2'b11;
    set_word(1, 16'hC002, 1'b1, 1'b0, 4'd0);
    obs();
    check("t3_cancel", app_cancel, 1);
    check("t3_last_masked", app_last, 0);
    cyc();
    clear_inputs();
    obs();
    check("t3_end_grant", grant, 0);
    check("t3_pkt_cnt", pkt_cnt, 3);
    check("t3_cancel_off", app_cancel, 0);

    // 4. Withdraw: req0 drops early_v in HEAD, twice.
    req_early_v[0] = 1'b1;
    cyc();
    obs();
    check("t4_head_grant", grant, 2'b01);
    check("t4_head_early", app_early_v, 1);
    cyc();
    req_early_v[0] = 1'b0;
    obs();
    check("t4_no_ready", req_ready_v, 0);
    cyc();
    req_early_v = 2'b11;
    obs();
    check("t4_idle", grant, 0);
    cyc();
    obs();
    check("t4_req0_still_next", grant, 2'b01);
    cyc();
    req_early_v[0] = 1'b0;
    cyc();
    obs();
    check("t4_idle2", grant, 0);
    cyc();
    app_ready_v = 1'b1;
    obs();
    check("t4_req1_granted", grant, 2'b10);
    check("t4_req1_ready", req_ready_v, 2'b10);
    cyc();
    app_ready_v = 1'b0;
    req_early_v = 2'b00;
    set_word(1, 16'hD001, 1'b1, 1'b0, 4'd0);
    obs();
    check("t4_data", app_data, 16'hD001);
    check("t4_last", app_last, 1);
    cyc();
    clear_inputs();
    obs();
    check("t4_pkt_cnt", pkt_cnt, 4);

    // 5. Reset mid-DATA, then a normal packet.
    req_early_v[0] = 1'b1;
    cyc();
    app_ready_v = 1'b1;
    obs();
    check("t5_head_grant", grant, 2'b01);
    cyc();
    app_ready_v = 1'b0;
    req_early_v = 2'b00;
    set_word(0, 16'hE001, 1'b0, 1'b0, 4'd0);
    obs();
    check("t5_data", app_data, 16'hE001);
    cyc();
    reset = 1'b1;
    set_word(0, 16'hE002, 1'b0, 1'b0, 4'd0);
    obs();
    check("t5_in_rst_grant", grant, 0);
    check("t5_in_rst_data", app_data, 0);
    cyc();
    reset = 1'b0;
    clear_inputs();
    obs();
    check("t5_post_grant", grant, 0);
    check("t5_post_pkt_cnt", pkt_cnt, 0);
    check("t5_post_cancel", app_cancel, 0);
    check("t5_post_early", app_early_v, 0);
    req_early_v[0] = 1'b1;
    cyc();
    app_ready_v = 1'b1;
    obs();
    check("t5_new_grant", grant, 2'b01);
    cyc();
    app_ready_v = 1'b0;
    req_early_v = 2'b00;
    set_word(0, 16'hF001, 1'b1, 1'b0, 4'd0);
    obs();
    check("t5_new_last", app_last, 1);
    cyc();
    clear_inputs();
    obs();
    check("t5_new_pkt_cnt", pkt_cnt, 1);
    check("t5_new_idle", grant, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
